// File: rtl/cpu_pkg.sv
// cpu_pkg: ASCII constants, hex-digit helper and the register-dump FSM state
// type shared by reg_dump_uart and its byte transmitter.
package cpu_pkg;

  localparam logic [7:0] CH_R  = 8'h52;  // 'R'
  localparam logic [7:0] CH_EQ = 8'h3D;  // '='
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_0  = 8'h30;  // '0'

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_CAPTURE,
    ST_SEND,
    ST_WAIT,
    ST_FIN
  } dump_state_t;

  // Uppercase hex digit for one nibble ('A' is 0x37 + 10).
  function automatic logic [7:0] hex2ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (CH_0 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: one-byte UART transmitter (start, 8 data LSB first,
// optional even parity, stop). Define REG_DUMP_PARITY_EN to add the parity bit.
// tx_done is high during the last cycle of the stop bit; the line is idle
// (and load is accepted) from the following cycle.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

`ifdef REG_DUMP_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int CW = $clog2(CLKS_PER_BIT + 1);

  logic [CW-1:0]    cnt;
  logic [3:0]       bitn;
  logic [NBITS-2:0] shreg;  // bits still to go out after the start bit

  assign tx_done = tx_busy && (cnt == CW'(CLKS_PER_BIT - 1)) && (bitn == 4'(NBITS - 1));

  // Baud counter and bit shifter; tx is registered so it never glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      cnt     <= '0;
      bitn    <= '0;
      shreg   <= '1;
    end else if (load && !tx_busy) begin
      tx      <= 1'b0;
      tx_busy <= 1'b1;
      cnt     <= '0;
      bitn    <= '0;
`ifdef REG_DUMP_PARITY_EN
      shreg   <= {1'b1, ^data, data};
`else
      shreg   <= {1'b1, data};
`endif
    end else if (tx_busy) begin
      if (cnt == CW'(CLKS_PER_BIT - 1)) begin
        cnt <= '0;
        if (bitn == 4'(NBITS - 1)) begin
          tx_busy <= 1'b0;
          tx      <= 1'b1;
        end else begin
          tx    <= shreg[0];
          shreg <= {1'b1, shreg[NBITS-2:1]};
          bitn  <= bitn + 4'd1;
        end
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/reg_dump_uart.sv
// reg_dump_uart: on start, reads registers 0..NREGS-1 through ra/rd and sends
// each as "Rn=HH\r\n" over tx. Define REG_DUMP_PARITY_EN for 8E1 frames.
// The register value is snapshotted once per line so a concurrent write can
// never split a line across two values.
module reg_dump_uart
  import cpu_pkg::*;
#(
  parameter  int CLK_HZ = 50_000_000,
  parameter  int BAUD   = 115200,
  parameter  int NREGS  = 8,
  localparam int RA_W   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [RA_W-1:0] ra,
  input  logic [7:0]      rd,
  output logic            tx,
  output logic            busy,
  output logic            done
);

  localparam int              CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam logic [RA_W-1:0] LAST_REG     = RA_W'(NREGS - 1);

  dump_state_t state;
  logic [2:0]  char_idx;
  logic [7:0]  snap;
  logic        load;
  logic [7:0]  cur_byte;
  logic        tx_busy;
  logic        tx_done;

  // Character of the current line selected by char_idx.
  always_comb begin
    cur_byte = CH_LF;
    case (char_idx)
      3'd0:    cur_byte = CH_R;
      3'd1:    cur_byte = CH_0 + 8'(ra);
      3'd2:    cur_byte = CH_EQ;
      3'd3:    cur_byte = hex2ascii(snap[7:4]);
      3'd4:    cur_byte = hex2ascii(snap[3:0]);
      3'd5:    cur_byte = CH_CR;
      default: cur_byte = CH_LF;
    endcase
  end

  // Dump sequencer. ra is already 0 when leaving IDLE, so the first line goes
  // straight to CAPTURE; later lines spend one ADDR cycle letting rd settle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      ra       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      load     <= 1'b0;
      char_idx <= '0;
      snap     <= '0;
    end else begin
      load <= 1'b0;
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            ra    <= '0;
            busy  <= 1'b1;
            state <= ST_CAPTURE;
          end
        end
        ST_ADDR: state <= ST_CAPTURE;
        ST_CAPTURE: begin
          snap     <= rd;
          char_idx <= '0;
          load     <= 1'b1;
          state    <= ST_SEND;
        end
        ST_SEND: begin
          // Transmitter takes the byte on this edge; hold load if it is not idle.
          if (tx_busy) load <= 1'b1;
          else         state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (tx_done) begin
            if (char_idx != 3'd6) begin
              char_idx <= char_idx + 3'd1;
              load     <= 1'b1;
              state    <= ST_SEND;
            end else if (ra != LAST_REG) begin
              ra    <= ra + RA_W'(1);
              state <= ST_ADDR;
            end else begin
              done  <= 1'b1;
              state <= ST_FIN;
            end
          end
        end
        ST_FIN: begin
          busy  <= 1'b0;
          ra    <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .data    (cur_byte),
    .tx      (tx),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

endmodule

// File: tb/tb_reg_dump_uart.sv
// Bench for reg_dump_uart at CLKS_PER_BIT=10: a cycle-sampling UART receiver
// collects bytes, and expected text is built from the register contents.
module tb_reg_dump_uart;

  localparam int CPB   = 10;
  localparam int NREGS = 8;
`ifdef REG_DUMP_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int NBYTES  = NREGS * 7;
  localparam int DUMP_CY = 2 + NREGS * 7 * NB * CPB + NREGS * 6 + (NREGS - 1) * 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] ra;
  logic [7:0] rd;
  logic       tx, busy, done;

  logic [7:0] regs [NREGS];
  assign rd = regs[ra];

  reg_dump_uart #(.CLK_HZ(10), .BAUD(1), .NREGS(NREGS)) dut (
    .clk(clk), .rst(rst), .start(start), .ra(ra), .rd(rd),
    .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cmps = 0;
  int errs = 0;
  int cyc = 0;
  int kcyc = 0;
  int done_cnt = 0;
  logic [7:0] rx_q  [$];
  logic [7:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    cmps++;
    assert (got === want) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // UART receiver: start detected at a falling sample, bits sampled mid-cell.
  int          mcnt = 0;
  bit          mact = 0;
  logic [10:0] mb;
  always @(negedge clk) begin
    if (rst) mact = 0;
    else if (!mact) begin
      if (tx === 1'b0) begin mact = 1; mcnt = 0; mb = '1; end
    end else mcnt++;
    if (mact && (mcnt % CPB) == CPB / 2) mb[mcnt / CPB] = tx;
    if (mact && mcnt == NB * CPB - 1) begin
`ifdef REG_DUMP_PARITY_EN
      check("frame_8E1", {31'd0, (mb[0] === 1'b0) && (mb[10] === 1'b1) && (mb[9] === ^mb[8:1])}, 32'd1);
`else
      check("frame_8N1", {31'd0, (mb[0] === 1'b0) && (mb[9] === 1'b1)}, 32'd1);
`endif
      rx_q.push_back(mb[8:1]);
      mact = 0;
    end
  end

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Expected dump text from the current register contents.
  task automatic build_exp();
    string hexs = "0123456789ABCDEF";
    exp_q.delete();
    for (int n = 0; n < NREGS; n++) begin
      exp_q.push_back(8'h52);
      exp_q.push_back(8'(8'h30 + n));
      exp_q.push_back(8'h3D);
      exp_q.push_back(hexs[regs[n][7:4]]);
      exp_q.push_back(hexs[regs[n][3:0]]);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  task automatic check_dump(input string tag, input int skip_line);
    check({tag, "_nbytes"}, rx_q.size(), NBYTES);
    for (int i = 0; i < NBYTES; i++)
      if (i / 7 != skip_line)
        check($sformatf("%s_byte%0d", tag, i), (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1; kcyc = cyc + 1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int i;
    for (i = 0; i < DUMP_CY + 200 && done !== 1'b1; i++) @(negedge clk);
    check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    check({tag, "_done_cycle"}, cyc - kcyc, DUMP_CY);
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    check({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
    check({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic rand_regs();
    for (int n = 0; n < NREGS; n++) regs[n] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    int d0;
    int t;
    logic [7:0] alt_q [$];
    bit ok_a, ok_b;

    for (int n = 0; n < NREGS; n++) regs[n] = 8'(n * 8'h11);
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ra", {29'd0, ra}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Dump 1: R0..R7 = 00,11,..,77 with first-frame latency checks.
    build_exp(); rx_q.delete(); d0 = done_cnt;
    pulse_start();
    check("k_busy", {31'd0, busy}, 32'd1);
    check("k_ra", {29'd0, ra}, 32'd0);
    @(negedge clk); check("k1_tx_idle", {31'd0, tx}, 32'd1);
    @(negedge clk); check("k2_tx_start", {31'd0, tx}, 32'd0);
    wait_done("d1");
    check_dump("d1", -1);
    repeat (5) @(negedge clk);
    check("d1_one_done", done_cnt - d0, 1);

    // Dump 2: random values, R3=AF, extra starts at +50 and +300 ignored.
    rand_regs(); regs[3] = 8'hAF;
    build_exp(); rx_q.delete(); d0 = done_cnt;
    pulse_start();
    while (cyc < kcyc + 50) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    check("retrig50_busy", {31'd0, busy}, 32'd1);
    while (cyc < kcyc + 300) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    check("retrig300_busy", {31'd0, busy}, 32'd1);
    wait_done("d2");
    check_dump("d2", -1);
    repeat (5) @(negedge clk);
    check("d2_one_done", done_cnt - d0, 1);

    // Dump 3: R5 rewritten 5A->C3 while its high nibble is on the line.
    rand_regs(); regs[5] = 8'h5A;
    build_exp(); rx_q.delete();
    pulse_start();
    for (t = 0; t < DUMP_CY && rx_q.size() < 38; t++) @(negedge clk);
    check("d3_reached_line5", {31'd0, rx_q.size() >= 38}, 32'd1);
    repeat (20) @(negedge clk);
    regs[5] = 8'hC3;
    alt_q = exp_q;
    alt_q[38] = 8'h43; alt_q[39] = 8'h33;
    wait_done("d3");
    check_dump("d3", 5);
    ok_a = 1; ok_b = 1;
    for (int i = 35; i < 42; i++) begin
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) ok_a = 0;
      if (i >= rx_q.size() || rx_q[i] !== alt_q[i]) ok_b = 0;
    end
    check("d3_line5_unmixed", {31'd0, ok_a || ok_b}, 32'd1);

    // Reset during byte 2, then a clean dump.
    repeat (4) @(negedge clk);
    rand_regs(); d0 = done_cnt;
    pulse_start();
    while (cyc < kcyc + 2 + 2 * (NB * CPB + 1) + 30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tx", {31'd0, tx}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_ra", {29'd0, ra}, 32'd0);
    check("midrst_no_done", done_cnt - d0, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    build_exp(); rx_q.delete();
    pulse_start();
    wait_done("d4");
    check_dump("d4", -1);

`ifdef REG_DUMP_PARITY_EN
    // Parity case: R1=07 gives '0' (even parity 0) and '7' (parity 1).
    repeat (4) @(negedge clk);
    rand_regs(); regs[1] = 8'h07;
    build_exp(); rx_q.delete();
    pulse_start();
    wait_done("d5");
    check_dump("d5", -1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule
